lift_step_sequencer: RTL and testbench

//   Sequences one 1-D lifting pass (predict or update) of the JPEG-2000 5/3 wavelet over the

---
 rtl/lift_pkg.sv | 17 +
 rtl/lift_step_sequencer_if.sv | 35 +++
 rtl/lift_lat_pipe.sv | 42 ++++
 rtl/lift_step_sequencer.sv | 136 +++++++++++++
 tb/tb_lift_step_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the 5/3 lifting step sequencer: lifting modes, FSM state codes
// and the default pixel-memory address width.
package lift_pkg;

    localparam int unsigned LIFT_ADDR_W = 7;

    localparam logic LIFT_PREDICT = 1'b0;
    localparam logic LIFT_UPDATE  = 1'b1;

    typedef logic [1:0] lift_state_t;

    localparam lift_state_t ST_IDLE  = 2'd0;
    localparam lift_state_t ST_READ  = 2'd1;
    localparam lift_state_t ST_DRAIN = 2'd2;
    localparam lift_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/lift_step_sequencer_if.sv
// Scheduler and pixel-memory side of the lifting sequencer. The sequencer is the slave;
// the scheduler/datapath side is the master.
interface lift_step_sequencer_if
    import lift_pkg::*;
#(
    parameter int unsigned ADDR_W = LIFT_ADDR_W
);

    logic              start;
    logic              mode;
    logic [ADDR_W:0]   num_pairs;
    logic [ADDR_W-1:0] pix_addr_l;
    logic [ADDR_W-1:0] pix_addr_r;
    logic [ADDR_W-1:0] pix_addr_even;
    logic [ADDR_W-1:0] pix_addr_odd;
    logic [ADDR_W-1:0] wr_addr;
    logic              pix_we_even;
    logic              pix_we_odd;
    logic              lift_mode;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, num_pairs,
        input  pix_addr_l, pix_addr_r, pix_addr_even, pix_addr_odd, wr_addr,
        input  pix_we_even, pix_we_odd, lift_mode, busy, done
    );

    modport slave (
        input  start, mode, num_pairs,
        output pix_addr_l, pix_addr_r, pix_addr_even, pix_addr_odd, wr_addr,
        output pix_we_even, pix_we_odd, lift_mode, busy, done
    );

endinterface

// File: rtl/lift_lat_pipe.sv
// Fixed-depth valid+address delay line matching the memory read plus datapath latency.
// Synchronous clear drops every in-flight sample.
module lift_lat_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_addr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_addr,
    output logic             pending
);

    // Every stage except the output stage; nonzero means more writes are still coming.
    localparam logic [DEPTH-1:0] UPSTREAM_MASK = ~(DEPTH'(1) << (DEPTH - 1));

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            addr_q[0]  <= in_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign pending   = |(valid_q & UPSTREAM_MASK);

endmodule

// File: rtl/lift_step_sequencer.sv
// Sequences one 5/3 lifting pass: walks the sample index, issues mirrored neighbour reads
// and delays each index through the datapath latency to drive the write-back enables.
module lift_step_sequencer
    import lift_pkg::*;
#(
    parameter int unsigned ADDR_W   = LIFT_ADDR_W,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lift_step_sequencer_if.slave bus
);

    localparam int unsigned LAT   = RD_LAT + PIPE_LAT;
    localparam int unsigned CNT_W = ADDR_W + 1;

    lift_state_t state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             mode_q, mode_d;

    logic [CNT_W-1:0]  last_idx;
    logic [ADDR_W-1:0] k_addr;
    logic              rd_active;
    logic              is_first;
    logic              is_last;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic              pipe_pending;

    logic [ADDR_W-1:0] addr_l;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_even;
    logic [ADDR_W-1:0] addr_odd;

    // Index counter carries one extra bit so N = 2**ADDR_W never wraps before the last compare.
    assign last_idx  = n_q - CNT_W'(1);
    assign k_addr    = k_q[ADDR_W-1:0];
    assign rd_active = (state_q == ST_READ);
    assign is_first  = (k_q == '0);
    assign is_last   = (k_q == last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            mode_q  <= LIFT_PREDICT;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d     = bus.num_pairs;
                    mode_d  = bus.mode;
                    k_d     = '0;
                    state_d = (bus.num_pairs == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (is_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!pipe_pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Symmetric extension: predict mirrors e[N]=e[N-1], update mirrors o[-1]=o[0].
    always_comb begin
        addr_l    = '0;
        addr_r    = '0;
        addr_even = '0;
        addr_odd  = '0;
        if (rd_active) begin
            addr_even = k_addr;
            addr_odd  = k_addr;
            if (mode_q == LIFT_UPDATE) begin
                addr_l = is_first ? '0 : k_addr - ADDR_W'(1);
                addr_r = k_addr;
            end else begin
                addr_l = k_addr;
                addr_r = is_last ? k_addr : k_addr + ADDR_W'(1);
            end
        end
    end

    lift_lat_pipe #(
        .DEPTH (LAT),
        .WIDTH (ADDR_W)
    ) u_lat_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (rd_active),
        .in_addr   (k_addr),
        .out_valid (wb_valid),
        .out_addr  (wb_addr),
        .pending   (pipe_pending)
    );

    assign bus.pix_addr_l    = addr_l;
    assign bus.pix_addr_r    = addr_r;
    assign bus.pix_addr_even = addr_even;
    assign bus.pix_addr_odd  = addr_odd;
    assign bus.wr_addr       = wb_valid ? wb_addr : '0;
    assign bus.pix_we_even   = wb_valid & (mode_q == LIFT_UPDATE);
    assign bus.pix_we_odd    = wb_valid & (mode_q == LIFT_PREDICT);
    assign bus.lift_mode     = mode_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_lift_step_sequencer.sv
// Scoreboard bench for lift_step_sequencer: each accepted start pushes the expected reads,
// write-backs and done cycle; a negedge monitor pops and compares them.
module tb_lift_step_sequencer;

    localparam int unsigned AW  = 7;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] l;
        logic [AW-1:0] r;
        logic [AW-1:0] e;
        logic [AW-1:0] o;
        logic          mode;
    } rd_exp_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic          we_even;
        logic          we_odd;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    rd_exp_t     rd_q[$];
    wr_exp_t     wr_q[$];
    int unsigned done_q[$];

    lift_step_sequencer_if #(.ADDR_W(AW)) bus ();

    lift_step_sequencer #(
        .ADDR_W   (AW),
        .PIPE_LAT (2),
        .RD_LAT   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start pulse in the current cycle and push what the spec says must follow.
    task automatic launch(input logic m, input int unsigned n);
        int unsigned s;
        rd_exp_t     re;
        wr_exp_t     we;
        s = cyc;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.num_pairs = (AW + 1)'(n);
        for (int unsigned k = 0; k < n; k++) begin
            re.cyc  = s + 1 + k;
            re.e    = AW'(k);
            re.o    = AW'(k);
            re.mode = m;
            if (m) begin
                re.l = (k == 0) ? AW'(0) : AW'(k - 1);
                re.r = AW'(k);
            end else begin
                re.l = AW'(k);
                re.r = (k == n - 1) ? AW'(k) : AW'(k + 1);
            end
            rd_q.push_back(re);
            we.cyc     = s + 1 + k + LAT;
            we.addr    = AW'(k);
            we.we_even = m;
            we.we_odd  = ~m;
            wr_q.push_back(we);
        end
        done_q.push_back((n == 0) ? s + 1 : s + 1 + n + LAT);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned waited = 0;
        while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && waited < budget) begin
            tick();
            waited++;
        end
        check("drain", 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'd0);
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        if (mon_en) begin
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                re = rd_q.pop_front();
                check("rd", {bus.pix_addr_l, bus.pix_addr_r, bus.pix_addr_even,
                             bus.pix_addr_odd, bus.lift_mode, bus.busy},
                      {re.l, re.r, re.e, re.o, re.mode, 1'b1});
            end else begin
                check("rd_idle", {bus.pix_addr_l, bus.pix_addr_r, bus.pix_addr_even,
                                  bus.pix_addr_odd}, 64'd0);
            end
            if (bus.pix_we_even || bus.pix_we_odd) begin
                if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    check("wr", {cyc, bus.wr_addr, bus.pix_we_even, bus.pix_we_odd},
                          {we.cyc, we.addr, we.we_even, we.we_odd});
                end else begin
                    check("wr_unexp", {bus.pix_we_even, bus.pix_we_odd}, 64'd0);
                end
            end
            if (bus.done) begin
                if (done_q.size() != 0) begin
                    check("done", 64'(cyc), 64'(done_q.pop_front()));
                end else begin
                    check("done_unexp", bus.done, 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.num_pairs = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset", {bus.pix_addr_l, bus.pix_addr_r, bus.pix_addr_even, bus.pix_addr_odd,
                        bus.wr_addr, bus.pix_we_even, bus.pix_we_odd, bus.lift_mode,
                        bus.busy, bus.done}, 64'd0);
        mon_en = 1'b1;
        tick();

        // Predict / update N=4, N=1 and the full 128-pair pass.
        launch(1'b0, 4);
        wait_idle(40);
        launch(1'b1, 4);
        wait_idle(40);
        launch(1'b0, 1);
        wait_idle(40);
        launch(1'b1, 1);
        wait_idle(40);
        launch(1'b0, 128);
        wait_idle(300);

        // Abort with rst while reading k=2; in-flight samples must never be written.
        launch(1'b1, 8);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("abort", {bus.busy, bus.pix_we_even, bus.pix_we_odd, bus.done}, 64'd0);
        tick();
        repeat (8) tick();
        launch(1'b0, 8);
        wait_idle(60);

        // Second start while busy must be ignored; N=0 gives only a done pulse.
        launch(1'b0, 4);
        tick();
        bus.start     = 1'b1;
        bus.mode      = 1'b1;
        bus.num_pairs = 8'd2;
        tick();
        bus.start = 1'b0;
        wait_idle(40);
        launch(1'b1, 0);
        wait_idle(20);
        repeat (4) tick();

        for (int unsigned i = 0; i < 4; i++) begin
            launch(1'($urandom_range(0, 1)), $urandom_range(1, 20));
            wait_idle(60);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
